// File: rtl/id_ctrl_stage_pkg.sv
// Shared decode types for the ID control stage: ALU operation codes, opcode
// constants, immediate/result source selects and the packed control word.
package id_ctrl_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD       = 5'b00000,
    ALU_SUB       = 5'b00001,
    ALU_AND       = 5'b00010,
    ALU_OR        = 5'b00011,
    ALU_XOR       = 5'b00100,
    ALU_SLL       = 5'b00101,
    ALU_SRL       = 5'b00110,
    ALU_SRA       = 5'b00111,
    ALU_ADDW      = 5'b01000,
    ALU_SUBW      = 5'b01001,
    ALU_SLT       = 5'b01010,
    ALU_SLTU      = 5'b01011,
    ALU_SLLW      = 5'b01100,
    ALU_SRLW      = 5'b01101,
    ALU_SRAW      = 5'b01110,
    ALU_SH1ADD    = 5'b10000,
    ALU_SH2ADD    = 5'b10001,
    ALU_SH3ADD    = 5'b10010,
    ALU_ADD_UW    = 5'b10011,
    ALU_SH1ADD_UW = 5'b10100,
    ALU_SH2ADD_UW = 5'b10101,
    ALU_SH3ADD_UW = 5'b10110
  } alu_op_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       a_src_pc;
    logic [2:0] imm_src;
    logic       reg_write;
    alu_op_t    alu_control;
    logic       branch;
    logic       jump;
    logic       is_jalr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/id_ctrl_stage_decode.sv
// Combinational RV64I(+W, +Zba) control decoder: raw instruction to ctrl_t.
module ctrl_decode
  import id_ctrl_stage_pkg::*;
#(
  parameter int EN_ZBA   = 1,
  parameter int EN_RV64W = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic       legal;
  ctrl_t      c;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct6 = instr[31:26];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    c = '0;
    c.alu_control = ALU_ADD;
    legal = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1;
        c.imm_src = IMM_I; c.result_src = RES_MEM;
        legal = (funct3 != 3'b111);
      end
      OPC_STORE: begin
        c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_S;
        legal = !funct3[2];
      end
      OPC_OP: begin
        c.reg_write = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: c.alu_control = ALU_ADD;
              3'b001: c.alu_control = ALU_SLL;
              3'b010: c.alu_control = ALU_SLT;
              3'b011: c.alu_control = ALU_SLTU;
              3'b100: c.alu_control = ALU_XOR;
              3'b101: c.alu_control = ALU_SRL;
              3'b110: c.alu_control = ALU_OR;
              3'b111: c.alu_control = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      c.alu_control = ALU_SUB;
            else if (funct3 == 3'b101) c.alu_control = ALU_SRA;
            else                       legal = 1'b0;
          end
          7'b0010000: begin
            if (EN_ZBA != 0 && funct3 == 3'b010)      c.alu_control = ALU_SH1ADD;
            else if (EN_ZBA != 0 && funct3 == 3'b100) c.alu_control = ALU_SH2ADD;
            else if (EN_ZBA != 0 && funct3 == 3'b110) c.alu_control = ALU_SH3ADD;
            else                                      legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_I;
        // RV64 immediate shifts carry a 6-bit shamt, so only instr[31:26] qualifies them
        case (funct3)
          3'b000: c.alu_control = ALU_ADD;
          3'b001: begin c.alu_control = ALU_SLL; legal = (funct6 == 6'b000000); end
          3'b010: c.alu_control = ALU_SLT;
          3'b011: c.alu_control = ALU_SLTU;
          3'b100: c.alu_control = ALU_XOR;
          3'b101: begin
            if (funct6 == 6'b000000)      c.alu_control = ALU_SRL;
            else if (funct6 == 6'b010000) c.alu_control = ALU_SRA;
            else                          legal = 1'b0;
          end
          3'b110: c.alu_control = ALU_OR;
          3'b111: c.alu_control = ALU_AND;
        endcase
      end
      OPC_OPIMM32: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_I;
        if (EN_RV64W == 0)                                  legal = 1'b0;
        else if (funct3 == 3'b000)                          c.alu_control = ALU_ADDW;
        else if (funct3 == 3'b001 && funct7 == 7'b0000000)  c.alu_control = ALU_SLLW;
        else if (funct3 == 3'b101 && funct7 == 7'b0000000)  c.alu_control = ALU_SRLW;
        else if (funct3 == 3'b101 && funct7 == 7'b0100000)  c.alu_control = ALU_SRAW;
        else                                                legal = 1'b0;
      end
      OPC_OP32: begin
        c.reg_write = 1'b1;
        if (EN_RV64W == 0)                                  legal = 1'b0;
        else if (funct7 == 7'b0000000 && funct3 == 3'b000)  c.alu_control = ALU_ADDW;
        else if (funct7 == 7'b0000000 && funct3 == 3'b001)  c.alu_control = ALU_SLLW;
        else if (funct7 == 7'b0000000 && funct3 == 3'b101)  c.alu_control = ALU_SRLW;
        else if (funct7 == 7'b0100000 && funct3 == 3'b000)  c.alu_control = ALU_SUBW;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)  c.alu_control = ALU_SRAW;
        else if (EN_ZBA != 0 && funct7 == 7'b0000100 && funct3 == 3'b000) c.alu_control = ALU_ADD_UW;
        else if (EN_ZBA != 0 && funct7 == 7'b0010000 && funct3 == 3'b010) c.alu_control = ALU_SH1ADD_UW;
        else if (EN_ZBA != 0 && funct7 == 7'b0010000 && funct3 == 3'b100) c.alu_control = ALU_SH2ADD_UW;
        else if (EN_ZBA != 0 && funct7 == 7'b0010000 && funct3 == 3'b110) c.alu_control = ALU_SH3ADD_UW;
        else                                                legal = 1'b0;
      end
      OPC_LUI: begin
        c.reg_write = 1'b1; c.imm_src = IMM_U; c.result_src = RES_IMM;
      end
      OPC_AUIPC: begin
        c.reg_write = 1'b1; c.imm_src = IMM_U; c.alu_src = 1'b1; c.a_src_pc = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1; c.imm_src = IMM_B;
        case (funct3)
          3'b000, 3'b001: c.alu_control = ALU_SUB;
          3'b100, 3'b101: c.alu_control = ALU_SLT;
          3'b110, 3'b111: c.alu_control = ALU_SLTU;
          default:        legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        c.reg_write = 1'b1; c.imm_src = IMM_J; c.result_src = RES_PC4; c.jump = 1'b1;
      end
      OPC_JALR: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_src = IMM_I;
        c.result_src = RES_PC4; c.jump = 1'b1; c.is_jalr = 1'b1;
        legal = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    // An illegal encoding must not cause any architectural side effect downstream
    if (!legal) begin
      c = '0;
      c.illegal = 1'b1;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode stage: combinational control decode feeding a main+skid buffer with
// registered-only in_ready, strict ordering and flush/reset discard.
module id_ctrl_stage
  import id_ctrl_stage_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int EN_ZBA   = 1,
  parameter int EN_RV64W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [1:0]      ResultSrc,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            ASrcPC,
  output logic [2:0]      ImmSrc,
  output logic            RegWrite,
  output logic [4:0]      ALUControl,
  output logic            Branch,
  output logic            Jump,
  output logic            is_jalr,
  output logic            illegal
);

  ctrl_t            ctrl_p0;
  logic             vld_p1;
  ctrl_t            ctrl_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [31:0]      instr_p1;
  logic             skid_vld_p1;
  ctrl_t            skid_ctrl_p1;
  logic [XLEN-1:0]  skid_pc_p1;
  logic [31:0]      skid_instr_p1;
  logic             accept;
  logic             take_main;
  logic             load_main_skid;
  logic             load_main_in;
  logic             load_skid;

  ctrl_decode #(
    .EN_ZBA   (EN_ZBA),
    .EN_RV64W (EN_RV64W)
  ) u_decode (
    .instr (instr),
    .ctrl  (ctrl_p0)
  );

  assign in_ready       = !rst && !skid_vld_p1;
  assign accept         = in_valid && in_ready;
  assign take_main      = !vld_p1 || out_ready;
  assign load_main_skid = take_main && skid_vld_p1;
  assign load_main_in   = take_main && !skid_vld_p1 && accept;
  assign load_skid      = !take_main && accept;

  // ---- p0 -> p1: main/skid buffer control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      skid_vld_p1  <= 1'b0;
      ctrl_p1      <= '0;
      skid_ctrl_p1 <= '0;
    end else begin
      if (load_main_skid)    ctrl_p1 <= skid_ctrl_p1;
      else if (load_main_in) ctrl_p1 <= ctrl_p0;
      if (load_skid)         skid_ctrl_p1 <= ctrl_p0;
      if (flush) begin
        vld_p1      <= 1'b0;
        skid_vld_p1 <= 1'b0;
      end else if (take_main) begin
        vld_p1      <= skid_vld_p1 || accept;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_skid) begin
      pc_p1    <= skid_pc_p1;
      instr_p1 <= skid_instr_p1;
    end else if (load_main_in) begin
      pc_p1    <= pc;
      instr_p1 <= instr;
    end
    if (load_skid) begin
      skid_pc_p1    <= pc;
      skid_instr_p1 <= instr;
    end
  end

  assign out_valid  = vld_p1;
  assign out_pc     = pc_p1;
  assign out_instr  = instr_p1;
  assign ResultSrc  = ctrl_p1.result_src;
  assign MemWrite   = ctrl_p1.mem_write;
  assign ALUSrc     = ctrl_p1.alu_src;
  assign ASrcPC     = ctrl_p1.a_src_pc;
  assign ImmSrc     = ctrl_p1.imm_src;
  assign RegWrite   = ctrl_p1.reg_write;
  assign ALUControl = ctrl_p1.alu_control;
  assign Branch     = ctrl_p1.branch;
  assign Jump       = ctrl_p1.jump;
  assign is_jalr    = ctrl_p1.is_jalr;
  assign illegal    = ctrl_p1.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed steps plus random traffic checked against a
// 2-deep FIFO model and a table-driven reference decoder.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [63:0] a_out_pc, b_out_pc;
  logic [31:0] a_out_instr, b_out_instr;
  logic [1:0]  a_rs, b_rs;
  logic [2:0]  a_imm, b_imm;
  logic [4:0]  a_alu, b_alu;
  logic        a_mw, a_as, a_pcs, a_rw, a_br, a_j, a_jr, a_ill;
  logic        b_mw, b_as, b_pcs, b_rw, b_br, b_j, b_jr, b_ill;
  logic [17:0] a_ctrl, b_ctrl;

  int n_assert = 0;
  int n_fail   = 0;
  logic [95:0] q[$];

  always #5 clk = ~clk;

  id_ctrl_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .pc(pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .ResultSrc(a_rs), .MemWrite(a_mw),
    .ALUSrc(a_as), .ASrcPC(a_pcs), .ImmSrc(a_imm), .RegWrite(a_rw), .ALUControl(a_alu),
    .Branch(a_br), .Jump(a_j), .is_jalr(a_jr), .illegal(a_ill)
  );

  id_ctrl_stage #(.XLEN(64), .EN_ZBA(0), .EN_RV64W(0)) dut_min (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .ResultSrc(b_rs), .MemWrite(b_mw),
    .ALUSrc(b_as), .ASrcPC(b_pcs), .ImmSrc(b_imm), .RegWrite(b_rw), .ALUControl(b_alu),
    .Branch(b_br), .Jump(b_j), .is_jalr(b_jr), .illegal(b_ill)
  );

  assign a_ctrl = {a_rs, a_mw, a_as, a_pcs, a_imm, a_rw, a_alu, a_br, a_j, a_jr, a_ill};
  assign b_ctrl = {b_rs, b_mw, b_as, b_pcs, b_imm, b_rw, b_alu, b_br, b_j, b_jr, b_ill};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: {ResultSrc,MemWrite,ALUSrc,ASrcPC,ImmSrc,RegWrite,ALUControl,Branch,Jump,is_jalr,illegal}
  function automatic logic [17:0] ref_ctrl(input logic [31:0] i, input bit zba, input bit w64);
    int base8[8] = '{0, 5, 10, 11, 4, 6, 3, 2};
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [5:0] f6;
    logic [1:0] rs;
    logic [2:0] imm;
    logic mw, as, pcs, rw, br, j, jr;
    int a;
    bit ok;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; f6 = i[31:26];
    rs = 0; imm = 0; mw = 0; as = 0; pcs = 0; rw = 0; br = 0; j = 0; jr = 0; a = 0; ok = 1;
    case (op)
      7'h03: begin ok = (f3 != 3'd7); rw = 1; as = 1; rs = 1; end
      7'h23: begin ok = (f3 < 3'd4); mw = 1; as = 1; imm = 1; end
      7'h33: begin
        rw = 1;
        if (f7 == 0) a = base8[f3];
        else if (f7 == 7'h20 && f3 == 0) a = 1;
        else if (f7 == 7'h20 && f3 == 5) a = 7;
        else if (zba && f7 == 7'h10 && f3 != 0 && !f3[0]) a = 15 + int'(f3) / 2;
        else ok = 0;
      end
      7'h13: begin
        rw = 1; as = 1; a = base8[f3];
        if (f3 == 1) ok = (f6 == 0);
        if (f3 == 5) begin
          if (f6 == 6'h10) a = 7;
          else ok = (f6 == 0);
        end
      end
      7'h1B: begin
        rw = 1; as = 1;
        if (f3 == 0) a = 8;
        else if (f3 == 1 && f7 == 0) a = 12;
        else if (f3 == 5 && f7 == 0) a = 13;
        else if (f3 == 5 && f7 == 7'h20) a = 14;
        else ok = 0;
        ok = ok && w64;
      end
      7'h3B: begin
        rw = 1;
        if (f7 == 0 && f3 == 0) a = 8;
        else if (f7 == 0 && f3 == 1) a = 12;
        else if (f7 == 0 && f3 == 5) a = 13;
        else if (f7 == 7'h20 && f3 == 0) a = 9;
        else if (f7 == 7'h20 && f3 == 5) a = 14;
        else if (zba && f7 == 7'h04 && f3 == 0) a = 19;
        else if (zba && f7 == 7'h10 && f3 != 0 && !f3[0]) a = 19 + int'(f3) / 2;
        else ok = 0;
        ok = ok && w64;
      end
      7'h37: begin rw = 1; imm = 3; rs = 3; end
      7'h17: begin rw = 1; imm = 3; as = 1; pcs = 1; end
      7'h63: begin
        br = 1; imm = 2;
        if (f3 == 2 || f3 == 3) ok = 0;
        else a = (f3 < 2) ? 1 : ((f3 < 6) ? 10 : 11);
      end
      7'h6F: begin rw = 1; imm = 4; rs = 2; j = 1; end
      7'h67: begin ok = (f3 == 0); rw = 1; as = 1; rs = 2; j = 1; jr = 1; end
      default: ok = 0;
    endcase
    if (!ok) return 18'd1;
    return {rs, mw, as, pcs, imm, rw, a[4:0], br, j, jr, 1'b0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[13] = '{7'h03, 7'h23, 7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37,
                            7'h17, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h0B};
    logic [6:0] f7;
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h10;
      3: f7 = 7'h04;
      default: f7 = 7'($urandom);
    endcase
    r = $urandom;
    return {f7, r[24:7], ops[$urandom_range(0, 12)]};
  endfunction

  // Apply one cycle of inputs, compare against the FIFO model, then advance it.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                      input logic ordy, input logic fl, input logic r);
    logic exp_rdy;
    logic [95:0] e;
    in_valid = v; instr = ins; pc = p; out_ready = ordy; flush = fl; rst = r;
    #1;
    exp_rdy = !r && (q.size() < 2);
    check("in_ready", a_in_ready, exp_rdy);
    check("in_ready_min", b_in_ready, exp_rdy);
    check("out_valid", a_out_valid, q.size() > 0);
    check("out_valid_min", b_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      check("out_pc", a_out_pc, e[95:32]);
      check("out_instr", a_out_instr, e[31:0]);
      check("ctrl", a_ctrl, ref_ctrl(e[31:0], 1'b1, 1'b1));
      check("out_pc_min", b_out_pc, e[95:32]);
      check("ctrl_min", b_ctrl, ref_ctrl(e[31:0], 1'b0, 1'b0));
    end
    if (r || fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back({p, ins});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    step(1, 32'h40B50533, 64'h100, 1, 0, 1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_in_ready", a_in_ready, 1'b0);

    // Single SUB, one-cycle latency
    step(1, 32'h40B50533, 64'h1000, 1, 0, 0);
    check("sub_alu", a_alu, 5'b00001);
    check("sub_regwrite", a_rw, 1'b1);
    check("sub_illegal", a_ill, 1'b0);

    // sh1add with and without Zba
    step(1, 32'h20B52533, 64'h1004, 1, 0, 0);
    check("sh1add_alu", a_alu, 5'b10000);
    check("sh1add_nozba_illegal", b_ill, 1'b1);
    check("sh1add_nozba_regwrite", b_rw, 1'b0);

    // Unknown opcode, then AUIPC
    step(1, 32'h0000007F, 64'h1008, 1, 0, 0);
    check("ill_flag", a_ill, 1'b1);
    check("ill_memwrite", a_mw, 1'b0);
    check("ill_jump", a_j, 1'b0);
    step(1, 32'h00000517, 64'h100C, 1, 0, 0);
    check("auipc_asrcpc", a_pcs, 1'b1);
    check("auipc_immsrc", a_imm, 3'b011);
    check("auipc_alu", a_alu, 5'b00000);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Back-pressure: three offered, two held, release drains in order
    step(1, 32'h00A00093, 64'h2000, 0, 0, 0);
    step(1, 32'h00B50533, 64'h2004, 0, 0, 0);
    check("held_in_ready", a_in_ready, 1'b0);
    step(1, 32'h40B50533, 64'h2008, 0, 0, 0);
    check("held_pc_stable", a_out_pc, 64'h2000);
    repeat (3) step(0, 32'h0, 64'h0, 1, 0, 0);

    // Flush with skid full and new input offered
    step(1, 32'h00A00093, 64'h3000, 0, 0, 0);
    step(1, 32'h00B50533, 64'h3004, 0, 0, 0);
    step(1, 32'h0000006F, 64'h3008, 0, 1, 0);
    check("flush_out_valid", a_out_valid, 1'b0);
    check("flush_in_ready", a_in_ready, 1'b1);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Entry accepted in the flush cycle is dropped
    step(1, 32'h00A00093, 64'h3100, 0, 0, 0);
    step(1, 32'h00B50533, 64'h3104, 0, 1, 0);
    check("flush_drop_valid", a_out_valid, 1'b0);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Reset with both entries held
    step(1, 32'h00A00093, 64'h4000, 0, 0, 0);
    step(1, 32'h00B50533, 64'h4004, 0, 0, 0);
    step(1, 32'h00C00113, 64'h4008, 0, 1, 1);
    check("rst_held_out_valid", a_out_valid, 1'b0);
    check("rst_held_in_ready", a_in_ready, 1'b0);
    step(0, 32'h0, 64'h0, 1, 0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 63) == 0);
    end
    repeat (3) step(0, 32'h0, 64'h0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
